// File: rtl/dac_spi_out.sv
// dac_spi_out: SPI master transmitter, 16-bit words, bit 0 first, idle-low clock
//   clock_i          system clock, all logic on its rising edge
//   reset_i          asynchronous active-high reset
//   data_in_i        word to send, [0:15], bit 0 goes out first
//   data_valid_i     load request, taken only while ready_o=1
//   ready_o          holding register empty
//   busy_o           transfer or inter-word gap in progress
//   data_sent_o      one-cycle pulse when the last bit of a word completes
//   spi_clock_out_o  SPI clock, idles low
//   spi_data_out_o   SPI data, changes only on falling SPI clock or at word start
//   spi_cs_n_o       chip select, active low
module dac_spi_out #(
    parameter int unsigned CLKDIV  = 4,
    parameter int unsigned GAPTIME = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [0:15] data_in_i,
    input  logic        data_valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        data_sent_o,
    output logic        spi_clock_out_o,
    output logic        spi_data_out_o,
    output logic        spi_cs_n_o
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
    state_t      state_q, state_d;
    logic [0:15] hold_q, hold_d, shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        ready_q, ready_d, busy_q, busy_d, sent_q, sent_d;
    logic        sclk_q, sclk_d, sdo_q, sdo_d, cs_n_q, cs_n_d;
    logic        half_done, gap_done;
    assign half_done = div_q == 16'(CLKDIV - 1);
    assign gap_done  = div_q == 16'(GAPTIME - 1);
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ready_d = ready_q;
        sent_d  = 1'b0;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        cs_n_d  = cs_n_q;
        // capture is independent of the serialiser state; a full register drops new words
        if (data_valid_i && ready_q) begin
            hold_d  = data_in_i;
            ready_d = 1'b0;
        end
        case (state_q)
            IDLE: if (!ready_q) begin
                shift_d = hold_q;
                ready_d = 1'b1;
                cs_n_d  = 1'b0;
                sdo_d   = hold_q[0];
                cnt_d   = '0;
                div_d   = '0;
                state_d = SETUP;
            end
            SETUP, LOW: begin
                div_d = half_done ? 16'd0 : div_q + 16'd1;
                if (half_done) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                div_d = half_done ? 16'd0 : div_q + 16'd1;
                if (half_done) begin
                    sclk_d = 1'b0;
                    if (cnt_q == 4'd15) begin
                        cs_n_d  = 1'b1;
                        sdo_d   = 1'b0;
                        sent_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        sdo_d   = shift_q[cnt_d];
                        state_d = LOW;
                    end
                end
            end
            GAP: begin
                div_d = gap_done ? 16'd0 : div_q + 16'd1;
                if (gap_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            cs_n_q  <= cs_n_d;
        end
    end
    assign ready_o         = ready_q;
    assign busy_o          = busy_q;
    assign data_sent_o     = sent_q;
    assign spi_clock_out_o = sclk_q;
    assign spi_data_out_o  = sdo_q;
    assign spi_cs_n_o      = cs_n_q;
endmodule

// File: tb/tb_dac_spi_out.sv
// tb_dac_spi_out: scoreboard bench for dac_spi_out (CLKDIV=4 and CLKDIV=1 instances)
module tb_dac_spi_out;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [0:15] din_a = '0, din_f = '0;
    logic dv_a = 1'b0, dv_f = 1'b0;
    logic ready_a, busy_a, sent_a, sclk_a, sdo_a, cs_a;
    logic ready_f, busy_f, sent_f, sclk_f, sdo_f, cs_f;
    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_out #(.CLKDIV(4), .GAPTIME(8)) u_dut (
        .clock_i(clk), .reset_i(rst), .data_in_i(din_a), .data_valid_i(dv_a),
        .ready_o(ready_a), .busy_o(busy_a), .data_sent_o(sent_a),
        .spi_clock_out_o(sclk_a), .spi_data_out_o(sdo_a), .spi_cs_n_o(cs_a));
    dac_spi_out #(.CLKDIV(1), .GAPTIME(8)) u_fast (
        .clock_i(clk), .reset_i(rst), .data_in_i(din_f), .data_valid_i(dv_f),
        .ready_o(ready_f), .busy_o(busy_f), .data_sent_o(sent_f),
        .spi_clock_out_o(sclk_f), .spi_data_out_o(sdo_f), .spi_cs_n_o(cs_f));

    logic [0:15] exp_q[$], expf_q[$];
    logic [0:15] word_q[$], wordf_q[$], rcv_q[$];
    int nbits_q[$], low_q[$], fall_q[$], first_rise_q[$], nbitsf_q[$], lowf_q[$];
    bit sent_rise_q[$];

    // wire monitor for the CLKDIV=4 instance
    logic p_sclk = 1'b0, p_cs = 1'b1, p_sent = 1'b0;
    logic [0:15] acc = '0;
    int nb = 0, fall_t = 0, rise_cnt = 0, sent_cnt = 0, sent_wide = 0, edge_hi = 0;
    always @(negedge clk) begin
        p_sclk <= sclk_a;
        p_cs   <= cs_a;
        p_sent <= sent_a;
        if (sclk_a && cs_a) edge_hi <= edge_hi + 1;
        if (sclk_a && !p_sclk && !cs_a) begin
            if (nb == 0) first_rise_q.push_back(cyc);
            acc      <= {acc[1:15], sdo_a};
            nb       <= nb + 1;
            rise_cnt <= rise_cnt + 1;
        end
        if (!cs_a && p_cs) begin
            nb     <= 0;
            fall_t <= cyc;
            fall_q.push_back(cyc);
        end
        if (cs_a && !p_cs) begin
            word_q.push_back(acc);
            nbits_q.push_back(nb);
            low_q.push_back(cyc - fall_t);
            sent_rise_q.push_back(sent_a);
        end
        if (sent_a && !p_sent) sent_cnt <= sent_cnt + 1;
        if (sent_a && p_sent) sent_wide <= sent_wide + 1;
    end

    // wire monitor for the CLKDIV=1 instance
    logic pf_sclk = 1'b0, pf_cs = 1'b1, pf_sent = 1'b0;
    logic [0:15] accf = '0;
    int nbf = 0, fallf_t = 0, last_rise_f = 0, bad_per_f = 0, edge_hi_f = 0, sentf_cnt = 0;
    always @(negedge clk) begin
        pf_sclk <= sclk_f;
        pf_cs   <= cs_f;
        pf_sent <= sent_f;
        if (sclk_f && cs_f) edge_hi_f <= edge_hi_f + 1;
        if (sclk_f && !pf_sclk && !cs_f) begin
            if (nbf > 0 && cyc - last_rise_f != 2) bad_per_f <= bad_per_f + 1;
            last_rise_f <= cyc;
            accf <= {accf[1:15], sdo_f};
            nbf  <= nbf + 1;
        end
        if (!cs_f && pf_cs) begin
            nbf     <= 0;
            fallf_t <= cyc;
        end
        if (cs_f && !pf_cs) begin
            wordf_q.push_back(accf);
            nbitsf_q.push_back(nbf);
            lowf_q.push_back(cyc - fallf_t);
        end
        if (sent_f && !pf_sent) sentf_cnt <= sentf_cnt + 1;
    end

    // SPI slave receiver on the same clock, fed by the CLKDIV=4 instance
    logic r_sclk = 1'b0, r_cs = 1'b1, data_received = 1'b0;
    logic [0:15] r_sh = '0;
    int r_n = 0, rcv_pulses = 0;
    always @(posedge clk) begin
        r_sclk        <= sclk_a;
        r_cs          <= cs_a;
        data_received <= 1'b0;
        if (!cs_a && sclk_a && !r_sclk) begin
            r_sh <= {r_sh[1:15], sdo_a};
            r_n  <= r_n + 1;
        end
        if (cs_a && !r_cs) begin
            if (r_n == 16) begin
                data_received <= 1'b1;
                rcv_q.push_back(r_sh);
            end
            r_n <= 0;
        end
    end
    always @(negedge clk) if (data_received) rcv_pulses <= rcv_pulses + 1;

    task automatic clear_mon;
        exp_q.delete(); word_q.delete(); nbits_q.delete(); low_q.delete();
        fall_q.delete(); first_rise_q.delete(); sent_rise_q.delete();
    endtask

    task automatic send_a(input logic [0:15] w);
        exp_q.push_back(w);
        din_a = w;
        dv_a  = 1'b1;
        @(negedge clk);
        dv_a  = 1'b0;
    endtask

    task automatic send_f(input logic [0:15] w);
        expf_q.push_back(w);
        din_f = w;
        dv_f  = 1'b1;
        @(negedge clk);
        dv_f  = 1'b0;
    endtask

    task automatic test_reset;
        int t, base, bad;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cs_a, sclk_a, sdo_a, ready_a, busy_a, sent_a} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected 100100", {cs_a, sclk_a, sdo_a, ready_a, busy_a, sent_a});
        end
        rst = 1'b0;
        @(negedge clk);
        base = rise_cnt;
        send_a(16'hA5C3);
        t = 0;
        while (rise_cnt < base + 5 && t < 500) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 500) begin n_fail++; $display("FAIL reset_wait_edges: got %0d edges expected 5", rise_cnt - base); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cs_a, sclk_a, sdo_a, ready_a, busy_a, sent_a} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_mid_word: got %b expected 100100", {cs_a, sclk_a, sdo_a, ready_a, busy_a, sent_a});
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({cs_a, sclk_a, sdo_a, ready_a, busy_a, sent_a} !== 6'b100100) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_idle_hold: got %0d changed cycles expected 0", bad); end
        clear_mon();
    endtask

    task automatic test_single_word;
        int t, cap, s0, w0, e0;
        logic [0:15] got, exp;
        s0 = sent_cnt; w0 = sent_wide; e0 = edge_hi;
        send_a(16'hA5C3);
        cap = cyc;
        n_checks++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL single_ready_drop: got %b expected 0", ready_a); end
        @(negedge clk);
        n_checks++;
        if ({busy_a, cs_a} !== 2'b10) begin n_fail++; $display("FAIL single_busy_cs: got %b expected 10", {busy_a, cs_a}); end
        t = 0;
        while (word_q.size() < 1 && t < 400) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 400) begin n_fail++; $display("FAIL single_timeout: got no word expected 1"); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (word_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d words expected 1", word_q.size()); end
        if (word_q.size() > 0 && exp_q.size() > 0) begin
            got = word_q.pop_front();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL single_word: got %h expected %h", got, exp); end
            n_checks++;
            if (nbits_q[0] != 16) begin n_fail++; $display("FAIL single_edges: got %0d expected 16", nbits_q[0]); end
            n_checks++;
            if (low_q[0] != 128) begin n_fail++; $display("FAIL single_cs_low: got %0d expected 128", low_q[0]); end
            n_checks++;
            if (sent_rise_q[0] != 1'b1) begin n_fail++; $display("FAIL single_sent_at_cs_rise: got 0 expected 1"); end
            n_checks++;
            if (fall_q[0] - cap != 1) begin n_fail++; $display("FAIL single_capture_to_cs: got %0d expected 1", fall_q[0] - cap); end
            n_checks++;
            if (first_rise_q[0] - fall_q[0] != 4) begin n_fail++; $display("FAIL single_first_edge: got %0d expected 4", first_rise_q[0] - fall_q[0]); end
        end
        n_checks++;
        if (sent_cnt - s0 != 1 || sent_wide != w0) begin
            n_fail++;
            $display("FAIL single_sent_pulse: got %0d pulses %0d wide expected 1 pulse 0 wide", sent_cnt - s0, sent_wide - w0);
        end
        n_checks++;
        if (edge_hi != e0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got clk_hi_cs_hi=%0d busy=%b expected 0 0", edge_hi - e0, busy_a); end
        clear_mon();
    endtask

    task automatic test_back_to_back;
        int t, s0, leaked;
        logic [0:15] got, exp;
        s0 = sent_cnt;
        send_a(16'h0001);
        t = 0;
        while (!busy_a && t < 20) begin @(negedge clk); t++; end
        send_a(16'h8000);
        din_a = 16'hDEAD;
        dv_a  = 1'b1;
        leaked = 0;
        repeat (50) begin @(negedge clk); if (ready_a) leaked++; end
        dv_a = 1'b0;
        n_checks++;
        if (leaked != 0) begin n_fail++; $display("FAIL b2b_hold_full: got ready=1 on %0d cycles expected 0", leaked); end
        t = 0;
        while (word_q.size() < 2 && t < 600) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 600) begin n_fail++; $display("FAIL b2b_timeout: got %0d words expected 2", word_q.size()); end
        repeat (300) @(negedge clk);
        n_checks++;
        if (word_q.size() != 2 || sent_cnt - s0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words %0d pulses expected 2 2", word_q.size(), sent_cnt - s0);
        end
        n_checks++;
        if (first_rise_q.size() < 2 || first_rise_q[1] - first_rise_q[0] != 137) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 137", first_rise_q.size() < 2 ? -1 : first_rise_q[1] - first_rise_q[0]);
        end
        while (word_q.size() > 0 && exp_q.size() > 0) begin
            got = word_q.pop_front();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b_word: got %h expected %h", got, exp); end
        end
        clear_mon();
    endtask

    task automatic test_clkdiv1;
        int t, s0, e0, b0;
        logic [0:15] got, exp;
        s0 = sentf_cnt; e0 = edge_hi_f; b0 = bad_per_f;
        send_f(16'hFFFF);
        t = 0;
        while (!busy_f && t < 20) begin @(negedge clk); t++; end
        send_f(16'h0000);
        t = 0;
        while (wordf_q.size() < 2 && t < 300) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 300) begin n_fail++; $display("FAIL div1_timeout: got %0d words expected 2", wordf_q.size()); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (wordf_q.size() != 2 || sentf_cnt - s0 != 2 || ready_f !== 1'b1) begin
            n_fail++;
            $display("FAIL div1_count: got %0d words %0d pulses ready=%b expected 2 2 1", wordf_q.size(), sentf_cnt - s0, ready_f);
        end
        while (wordf_q.size() > 0 && expf_q.size() > 0) begin
            got = wordf_q.pop_front();
            exp = expf_q.pop_front();
            n_checks++;
            if (got !== exp || nbitsf_q[0] != 16 || lowf_q[0] != 32) begin
                n_fail++;
                $display("FAIL div1_word: got %h/%0d bits/%0d low expected %h/16/32", got, nbitsf_q[0], lowf_q[0], exp);
            end
            void'(nbitsf_q.pop_front());
            void'(lowf_q.pop_front());
        end
        n_checks++;
        if (bad_per_f != b0 || edge_hi_f != e0) begin
            n_fail++;
            $display("FAIL div1_toggle: got %0d bad periods %0d clk_hi_cs_hi expected 0 0", bad_per_f - b0, edge_hi_f - e0);
        end
    endtask

    task automatic test_simultaneous;
        int t, s;
        logic [0:15] got, exp;
        send_a(16'h5555);
        t = 0;
        while (!sent_a && t < 400) begin @(negedge clk); t++; end
        n_checks++;
        if (t >= 400) begin n_fail++; $display("FAIL simul_timeout: got no data_sent expected 1"); end
        s = cyc;
        send_a(16'h1234);
        n_checks++;
        if (ready_a !== 1'b0) begin n_fail++; $display("FAIL simul_ready_drop: got %b expected 0", ready_a); end
        t = 0;
        while (word_q.size() < 2 && t < 400) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        n_checks++;
        if (fall_q.size() < 2 || fall_q[1] - s != 9) begin
            n_fail++;
            $display("FAIL simul_start: got %0d expected 9", fall_q.size() < 2 ? -1 : fall_q[1] - s);
        end
        n_checks++;
        if (word_q.size() != 2) begin n_fail++; $display("FAIL simul_count: got %0d expected 2", word_q.size()); end
        while (word_q.size() > 0 && exp_q.size() > 0) begin
            got = word_q.pop_front();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL simul_word: got %h expected %h", got, exp); end
        end
        clear_mon();
    endtask

    task automatic test_loopback;
        int t, p0;
        logic [0:15] got, exp;
        rcv_q.delete();
        p0 = rcv_pulses;
        for (int i = 0; i < 8; i++) begin
            t = 0;
            while (!ready_a && t < 400) begin @(negedge clk); t++; end
            send_a(16'($urandom));
        end
        t = 0;
        while (rcv_q.size() < 8 && t < 2000) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        n_checks++;
        if (rcv_q.size() != 8 || rcv_pulses - p0 != 8) begin
            n_fail++;
            $display("FAIL loop_count: got %0d words %0d pulses expected 8 8", rcv_q.size(), rcv_pulses - p0);
        end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            got = rcv_q.pop_front();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL loop_word: got %h expected %h", got, exp); end
        end
        clear_mon();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_clkdiv1();
        test_simultaneous();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_spi_out.md
# dac_spi_out

SPI master transmitter that serialises 16-bit words onto a three-wire SPI link (clock, data, active-low chip select) for the DAC and the board's SPI peripherals. It is the transmit-side counterpart of the team's SPI slave receiver: idle-low SPI clock, data stable on the rising edge, bit index 0 first. A one-word holding register lets the core queue the next word while the current one shifts out.

## Interface
- CLKDIV, 4: system clocks per SPI half-period; legal range 1..65535.
- GAPTIME, 8: system clocks between words, with clock low and chip select high; legal range 1..65535.

- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- data_in  in  16  word to send, indexed [0:15]; data_in[0] goes on the wire first.
- data_valid  in  1  load request; captured only when ready=1.
- ready  out  1  holding register is empty.
- busy  out  1  transfer or gap in progress (state != idle).
- data_sent  out  1  one-cycle pulse when a word's last bit completes.
- spi_clock_out  out  1  SPI clock; idles low.
- spi_data_out  out  1  SPI data.
- spi_cs_n  out  1  chip select, active low.

## Operation
- All outputs are registered. Reset values: spi_clock_out=0, spi_data_out=0, spi_cs_n=1, ready=1, busy=0, data_sent=0. The holding register, shift register, bit counter (4 bits) and divider counter (16 bits) clear to 0, and the state goes to idle.
- Holding register behaviour:
  - data_valid=1 with ready=1 captures data_in; ready=0 from the next cycle.
  - data_valid=1 with ready=0 is ignored; the word is dropped and no state changes.
  - A capture is allowed in any state, including during a transfer.
- States are idle, setup, high, low and gap:
  - **idle:** if the holding register is full, move it to the shift register and set ready=1 next cycle. Also drive spi_cs_n<=0 and spi_data_out<=word[0], clear the bit counter, then go to setup. If the holding register is empty, stay in idle.
  - **setup:** hold CLKDIV cycles with the clock low, then spi_clock_out<=1 and go to high.
  - **high:** hold CLKDIV cycles, then spi_clock_out<=0.
    - If bit counter = 15: spi_cs_n<=1, spi_data_out<=0, data_sent<=1 for one cycle, go to gap.
    - Otherwise: increment the bit counter, spi_data_out<=word[count+1], go to low.
  - **low:** hold CLKDIV cycles, then spi_clock_out<=1 and go to high.
  - **gap:** hold GAPTIME cycles, then go to idle.
- Data changes only on the system-clock edge where spi_clock_out falls, or on entry to setup. Data is therefore stable for at least CLKDIV cycles on each side of every rising edge.
- Exactly 16 rising edges occur per word. The clock is always low while spi_cs_n=1.
- Simultaneous events:
  - In the idle cycle that transfers the holding register, ready is still 0, so data_valid in that cycle is ignored.
  - A capture in the same cycle as data_sent is accepted; that word starts after the gap.
- Reset mid-word forces the outputs to their reset values immediately and discards both registers. The downstream receiver recovers through its own idle timeout.
- Constraint: CLKDIV in system clocks must stay below 512 receiver clocks, so the downstream receiver's stuck-clock abort never triggers during a word.

## Timing
- Capture to spi_cs_n low:
  - 2 cycles when idle: capture edge, then the idle transfer edge.
  - Otherwise the idle cycle after gap.
- First rising SPI edge comes CLKDIV cycles after spi_cs_n falls.
- spi_cs_n low to high: 32*CLKDIV cycles.
- data_sent is asserted in the cycle spi_cs_n returns high.
- Back-to-back word period with the holding register kept full: 32*CLKDIV + GAPTIME + 1 cycles.
- busy rises with spi_cs_n falling and falls on the cycle after the gap ends.

## Test plan
- **Reset values and idle:** assert reset mid-word (after the 5th rising SPI edge), release, no data_valid → spi_cs_n=1, spi_clock_out=0, spi_data_out=0, ready=1, busy=0 within the reset cycle. The outputs then stay constant for 200 cycles.
- **Single word:** CLKDIV=4, GAPTIME=8, data_in=16'hA5C3, one data_valid pulse. Required response:
  - the wire bits sampled on 16 rising edges equal data_in[0]..data_in[15];
  - spi_cs_n is low for exactly 128 cycles;
  - data_sent is one cycle wide and coincides with spi_cs_n rising.
- **Back-to-back:** load 16'h0001, then 16'h8000 while busy; hold data_valid on a third word while ready=0. Required response:
  - the two words go out in order with rising-edge spacing of 137 cycles;
  - the third word is dropped, giving exactly two data_sent pulses.
- **CLKDIV=1 corner:** stream 16'hFFFF, then 16'h0000 → the clock toggles every cycle and the data is correct. No edge occurs with spi_cs_n=1.
- **Simultaneous capture:** assert data_valid in the data_sent cycle with 16'h1234 → accepted (ready drops next cycle). The word starts GAPTIME+1 cycles later.
- **Loopback:** feed the outputs into the team's SPI slave receiver running on the same clock, and send 8 random words → each received word equals the word sent. The receiver's data_received pulses 8 times.
